// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II sequential multiplier.
// Covers the op encoding, the FSM state codes and the op type.
package nios2_mul_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_MUL    = 2'd0;
   localparam op_t OP_MULXUU = 2'd1;
   localparam op_t OP_MULXSS = 2'd2;
   localparam op_t OP_MULXSU = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t MULT = 2'd1;
   localparam state_t FIX  = 2'd2;
   localparam state_t DONE = 2'd3;

endpackage

// File: rtl/nios2_mul_half_cell.sv
// Unsigned HALF x HALF multiplier.
// It is kept as a bare product so that synthesis maps it onto a single DSP element.
module nios2_mul_half_cell #(
   parameter int HALF = 16
) (
   input  logic [HALF-1:0]   a,
   input  logic [HALF-1:0]   b,
   output logic [2*HALF-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/nios2_mul_seq.sv
// Sequential multiplier that reuses one half-width cell over up to four cycles.
// A FIX cycle turns the unsigned high word into its signed or mixed-sign form.
module nios2_mul_seq
   import nios2_mul_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  op_t               in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              busy
);

   localparam int HALF  = DATA_W / 2;
   localparam int ACC_W = 2 * DATA_W;

   state_t              state;
   op_t                 op_q;
   logic [DATA_W-1:0]   src1_q;
   logic [DATA_W-1:0]   src2_q;
   logic [ACC_W-1:0]    acc;
   logic [1:0]          idx;

   logic [HALF-1:0]     mul_a;
   logic [HALF-1:0]     mul_b;
   logic [2*HALF-1:0]   pp;
   logic [ACC_W-1:0]    pp_ext;
   logic [ACC_W-1:0]    pp_shifted;
   logic [ACC_W-1:0]    acc_sum;
   logic [DATA_W-1:0]   corr1;
   logic [DATA_W-1:0]   corr2;
   logic [DATA_W-1:0]   hi_fixed;

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

   // Operand halves and accumulator alignment for the current partial product.
   always_comb begin
      mul_a      = src1_q[HALF-1:0];
      mul_b      = src2_q[HALF-1:0];
      pp_shifted = pp_ext;
      case (idx)
         2'd1: begin
            mul_a      = src1_q[DATA_W-1:HALF];
            pp_shifted = pp_ext << HALF;
         end
         2'd2: begin
            mul_b      = src2_q[DATA_W-1:HALF];
            pp_shifted = pp_ext << HALF;
         end
         2'd3: begin
            mul_a      = src1_q[DATA_W-1:HALF];
            mul_b      = src2_q[DATA_W-1:HALF];
            pp_shifted = pp_ext << DATA_W;
         end
         default: ;
      endcase
   end

   nios2_mul_half_cell #(.HALF(HALF)) u_half_cell (
      .a (mul_a),
      .b (mul_b),
      .p (pp)
   );

   assign pp_ext  = {{DATA_W{1'b0}}, pp};
   assign acc_sum = acc + pp_shifted;

   // Each negative operand makes the unsigned high word too large by the other operand.
   assign corr1    = ((op_q == OP_MULXSS || op_q == OP_MULXSU) && src1_q[DATA_W-1]) ? src2_q : '0;
   assign corr2    = ((op_q == OP_MULXSS) && src2_q[DATA_W-1]) ? src1_q : '0;
   assign hi_fixed = acc[ACC_W-1:DATA_W] - corr1 - corr2;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         op_q       <= OP_MUL;
         src1_q     <= '0;
         src2_q     <= '0;
         acc        <= '0;
         idx        <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q   <= in_op;
                  src1_q <= in_src1;
                  src2_q <= in_src2;
                  acc    <= '0;
                  idx    <= '0;
                  state  <= MULT;
               end
            end
            MULT: begin
               acc <= acc_sum;
               idx <= idx + 2'd1;
               // The high-half product cannot reach the low word, so MUL stops early.
               if (op_q == OP_MUL && idx == 2'd2) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  out_result <= acc_sum[DATA_W-1:0];
               end else if (idx == 2'd3) begin
                  state <= FIX;
               end
            end
            FIX: begin
               acc        <= {hi_fixed, acc[DATA_W-1:0]};
               out_result <= hi_fixed;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Scoreboard bench for nios2_mul_seq.
// It checks directed and random products, latency, backpressure and reset abandonment.
module tb_nios2_mul_seq;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] sbq[$];

   nios2_mul_seq #(.DATA_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference result from full-width 64-bit products.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ua, ub, sa, sb, p;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         2'd0:    begin p = ua * ub; return p[31:0]; end
         2'd1:    p = ua * ub;
         2'd2:    p = sa * sb;
         default: p = sa * ub;
      endcase
      return p[63:32];
   endfunction

   // Scoreboard consumer: every output handshake must match the oldest pending result.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         checkOutput("sb_pending", (sbq.size() != 0), 1'b1);
         if (sbq.size() != 0)
            checkOutput("result", out_result, sbq.pop_front());
      end
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard;
      int lat;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("ready_before", in_ready, 1'b1);
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      sbq.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 30);
      checkOutput("latency", lat, (op == 2'd0) ? 4 : 6);
   endtask

   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(op, a, b);
      @(posedge clk);
      #1;
      checkOutput("ready_after", in_ready, 1'b1);
   endtask

   initial begin
      int guard;
      logic [31:0] held;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_src1   = '0;
      in_src2   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_result", out_result, 32'h0);
      @(posedge clk);
      #1;

      runOp(2'd0, 32'h0001_0003, 32'h0002_0005);
      checkOutput("mul_const", model(2'd0, 32'h0001_0003, 32'h0002_0005), 32'h000B_000F);
      runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(2'd2, 32'h8000_0000, 32'h8000_0000);
      runOp(2'd2, 32'h7FFF_FFFF, 32'h8000_0000);
      runOp(2'd3, 32'hFFFF_FFFF, 32'h0000_0002);
      runOp(2'd3, 32'h0000_0002, 32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++)
         runOp(2'($urandom_range(0, 3)), $urandom, $urandom);

      // Backpressure with a stray request while busy.
      out_ready = 1'b0;
      held = model(2'd2, 32'h1234_5678, 32'h9ABC_DEF0);
      applyStimulus(2'd2, 32'h1234_5678, 32'h9ABC_DEF0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = 2'd0;
      in_src1  = 32'd7;
      in_src2  = 32'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", out_valid, 1'b1);
         checkOutput("bp_result", out_result, held);
         checkOutput("bp_in_ready", in_ready, 1'b0);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_released_valid", out_valid, 1'b0);
      checkOutput("bp_released_ready", in_ready, 1'b1);
      repeat (10) @(posedge clk);
      #1;

      // Reset during the third partial product abandons the op.
      in_valid = 1'b1;
      in_op    = 2'd2;
      in_src1  = 32'hDEAD_BEEF;
      in_src2  = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      checkOutput("mid_rst_in_ready", in_ready, 1'b1);
      checkOutput("mid_rst_out_valid", out_valid, 1'b0);
      checkOutput("mid_rst_out_result", out_result, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      runOp(2'd0, 32'd3, 32'd5);

      guard = 0;
      while (sbq.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("sb_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
